basemul_acc: RTL and testbench

- Pipelined NTT-domain base multiplier with accumulation: computes r = sum over k=0..K-1 of a_k*b_k in Zq[X]/(X^2 - ±zeta). This is the polyvec_basemul_acc inner product for Kyber matrix-vector products.
- Sits between the coefficient RAM read ports and the writeback/invNTT path.
- Adds the following: valid framing, K-term accumulation, a per-term zeta sign mode, and output reduction to the centred representative.

---
 rtl/kyber_pkg.sv | 15 +
 rtl/basemul_acc_if.sv | 31 +++
 rtl/basemul_acc_barrett.sv | 19 +
 rtl/basemul_acc_fqmul.sv | 35 +++
 rtl/basemul_acc.sv | 134 +++++++++++++
 tb/tb_basemul_acc.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/kyber_pkg.sv
// Kyber arithmetic constants and the coefficient type shared by the basemul
// accumulator, its arithmetic sub-modules and its testbench.
package kyber_pkg;

   localparam int COEF_W      = 16;
   localparam int KYBER_Q     = 3329;
   localparam int KYBER_K     = 3;
   localparam int BARRETT_V   = 20159;
   localparam int MONT_R_MODQ = 2285;
   // q^-1 mod 2^16 as a signed 16-bit value, used by the Montgomery reduction
   localparam int MONT_QINV   = -3327;

   typedef logic signed [COEF_W-1:0] coef_t;

endpackage

// File: rtl/basemul_acc_if.sv
// Term-input / result-output bundle of the NTT-domain base multiplier.
// master drives terms and observes results; slave is the accumulator itself.
interface basemul_acc_if #(
   parameter int WIDTH = 16,
   parameter int K     = 3
);
   localparam int TW = (K > 1) ? $clog2(K) : 1;

   logic                    in_valid;
   logic                    in_neg;
   logic signed [WIDTH-1:0] a0;
   logic signed [WIDTH-1:0] a1;
   logic signed [WIDTH-1:0] b0;
   logic signed [WIDTH-1:0] b1;
   logic signed [WIDTH-1:0] zeta;
   logic                    out_valid;
   logic signed [WIDTH-1:0] r0;
   logic signed [WIDTH-1:0] r1;
   logic [TW-1:0]           term_idx;

   modport master (
      output in_valid, in_neg, a0, a1, b0, b1, zeta,
      input  out_valid, r0, r1, term_idx
   );

   modport slave (
      input  in_valid, in_neg, a0, a1, b0, b1, zeta,
      output out_valid, r0, r1, term_idx
   );

endinterface

// File: rtl/basemul_acc_barrett.sv
// Combinational Barrett reduction to the centred representative in
// [-(Q-1)/2, (Q-1)/2]; exact for |i_x| < 2^15.
module barrett_reduce
   import kyber_pkg::*;
#(
   parameter int WIDTH = COEF_W,
   parameter int Q     = KYBER_Q
) (
   input  logic signed [31:0]      i_x,
   output logic signed [WIDTH-1:0] o_r
);

   logic signed [31:0] w_t;

   // Rounded quotient x/Q: the +2^25 term turns the shift into round-to-nearest
   assign w_t = (BARRETT_V * i_x + 32'sd33554432) >>> 26;
   assign o_r = WIDTH'(i_x - w_t * Q);

endmodule

// File: rtl/basemul_acc_fqmul.sv
// Montgomery multiply: o_r == i_a*i_b*2^-16 mod Q, in (-Q, Q), delivered LAT
// cycles after the operands are presented.
module fqmul
   import kyber_pkg::*;
#(
   parameter int WIDTH = COEF_W,
   parameter int Q     = KYBER_Q,
   parameter int LAT   = 1
) (
   input  logic                    clk,
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   output logic signed [WIDTH-1:0] o_r
);

   logic signed [31:0]      w_prod;
   logic signed [15:0]      w_t;
   logic signed [WIDTH-1:0] w_mont;
   logic signed [WIDTH-1:0] r_pipe [LAT];

   assign w_prod = 32'(i_a) * 32'(i_b);
   assign w_t    = 16'(w_prod * MONT_QINV);
   assign w_mont = WIDTH'((w_prod - 32'(w_t) * Q) >>> 16);

   // NOTE: pure datapath registers carry no reset; qualifying valids are reset upstream.
   always_ff @(posedge clk) begin
      r_pipe[0] <= w_mont;
      for (int i = 1; i < LAT; i++) begin
         r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_r = r_pipe[LAT-1];

endmodule

// File: rtl/basemul_acc.sv
// Pipelined Kyber basemul with K-term accumulation:
// r = sum a_k*b_k in Zq[X]/(X^2 - +-zeta), centred output, LAT = 2*FQMUL_LAT+3.
module basemul_acc
   import kyber_pkg::*;
#(
   parameter int WIDTH     = COEF_W,
   parameter int K         = KYBER_K,
   parameter int Q         = KYBER_Q,
   parameter int FQMUL_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   basemul_acc_if.slave  bus
);

   localparam int TW   = (K > 1) ? $clog2(K) : 1;
   localparam int PLAT = 2 * FQMUL_LAT;

   typedef logic signed [WIDTH-1:0] word_t;

   word_t              w_zeta_sel;
   word_t              w_m00, w_m01, w_m10, w_m11, w_p;
   word_t              w_s0, w_s1, w_f0, w_f1;
   logic signed [31:0] w_pair0, w_pair1;

   word_t              r_zeta_d [FQMUL_LAT];
   word_t              r_m00_d  [FQMUL_LAT];
   word_t              r_m01_d  [FQMUL_LAT];
   word_t              r_m10_d  [FQMUL_LAT];
   word_t              r_s0, r_s1;
   word_t              r_acc0, r_acc1;
   word_t              r_r0, r_r1;
   logic [PLAT-1:0]    r_vld;
   logic               r_s_vld;
   logic               r_done;
   logic               r_out_valid;
   logic [TW-1:0]      r_acc_cnt;
   logic [TW-1:0]      r_in_cnt;

   assign w_zeta_sel = bus.in_neg ? -bus.zeta : bus.zeta;

   // First product rank: all four coefficient cross products in parallel
   fqmul #(.WIDTH(WIDTH), .Q(Q), .LAT(FQMUL_LAT)) u_fq_m00 (
      .clk(clk), .i_a(bus.a0), .i_b(bus.b0), .o_r(w_m00));
   fqmul #(.WIDTH(WIDTH), .Q(Q), .LAT(FQMUL_LAT)) u_fq_m01 (
      .clk(clk), .i_a(bus.a0), .i_b(bus.b1), .o_r(w_m01));
   fqmul #(.WIDTH(WIDTH), .Q(Q), .LAT(FQMUL_LAT)) u_fq_m10 (
      .clk(clk), .i_a(bus.a1), .i_b(bus.b0), .o_r(w_m10));
   fqmul #(.WIDTH(WIDTH), .Q(Q), .LAT(FQMUL_LAT)) u_fq_m11 (
      .clk(clk), .i_a(bus.a1), .i_b(bus.b1), .o_r(w_m11));

   always_ff @(posedge clk) begin
      r_zeta_d[0] <= w_zeta_sel;
      r_m00_d[0]  <= w_m00;
      r_m01_d[0]  <= w_m01;
      r_m10_d[0]  <= w_m10;
      for (int i = 1; i < FQMUL_LAT; i++) begin
         r_zeta_d[i] <= r_zeta_d[i-1];
         r_m00_d[i]  <= r_m00_d[i-1];
         r_m01_d[i]  <= r_m01_d[i-1];
         r_m10_d[i]  <= r_m10_d[i-1];
      end
   end

   // Second product rank: a1*b1 twisted by the signed zeta of the same term
   fqmul #(.WIDTH(WIDTH), .Q(Q), .LAT(FQMUL_LAT)) u_fq_p (
      .clk(clk), .i_a(w_m11), .i_b(r_zeta_d[FQMUL_LAT-1]), .o_r(w_p));

   assign w_pair0 = 32'(r_m00_d[FQMUL_LAT-1]) + 32'(w_p);
   assign w_pair1 = 32'(r_m01_d[FQMUL_LAT-1]) + 32'(r_m10_d[FQMUL_LAT-1]);

   barrett_reduce #(.WIDTH(WIDTH), .Q(Q)) u_bar_s0 (.i_x(w_pair0), .o_r(w_s0));
   barrett_reduce #(.WIDTH(WIDTH), .Q(Q)) u_bar_s1 (.i_x(w_pair1), .o_r(w_s1));

   always_ff @(posedge clk) begin
      r_s0 <= w_s0;
      r_s1 <= w_s1;
   end

   barrett_reduce #(.WIDTH(WIDTH), .Q(Q)) u_bar_f0 (.i_x(32'(r_acc0)), .o_r(w_f0));
   barrett_reduce #(.WIDTH(WIDTH), .Q(Q)) u_bar_f1 (.i_x(32'(r_acc1)), .o_r(w_f1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld       <= '0;
         r_s_vld     <= 1'b0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         r_acc_cnt   <= '0;
         r_in_cnt    <= '0;
         r_acc0      <= '0;
         r_acc1      <= '0;
         r_r0        <= '0;
         r_r1        <= '0;
      end else begin
         r_vld   <= {r_vld[PLAT-2:0], bus.in_valid};
         r_s_vld <= r_vld[PLAT-1];
         r_done  <= 1'b0;

         // Count 0 loads rather than adds, so a new sum never inherits the old one
         if (r_s_vld) begin
            if (r_acc_cnt == '0) begin
               r_acc0 <= r_s0;
               r_acc1 <= r_s1;
            end else begin
               r_acc0 <= r_acc0 + r_s0;
               r_acc1 <= r_acc1 + r_s1;
            end
            if (r_acc_cnt == TW'(K-1)) begin
               r_acc_cnt <= '0;
               r_done    <= 1'b1;
            end else begin
               r_acc_cnt <= r_acc_cnt + TW'(1);
            end
         end

         r_out_valid <= r_done;
         if (r_done) begin
            r_r0 <= w_f0;
            r_r1 <= w_f1;
         end

         if (bus.in_valid) begin
            r_in_cnt <= (r_in_cnt == TW'(K-1)) ? '0 : r_in_cnt + TW'(1);
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.r0        = r_r0;
   assign bus.r1        = r_r1;
   assign bus.term_idx  = r_in_cnt;

endmodule

// File: tb/tb_basemul_acc.sv
// Self-checking bench for basemul_acc: directed scenarios with known sums plus
// randomized terms checked against a plain modular-arithmetic reference model.
module tb_basemul_acc;
   import kyber_pkg::*;

   localparam int WIDTH = 16;
   localparam int K     = 3;
   localparam int LAT   = 5;
   localparam int R     = MONT_R_MODQ;
   localparam longint RINV = 169;   // 2^-16 mod q

   typedef struct packed {int r0; int r1; int cyc;} pulse_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   basemul_acc_if #(.WIDTH(WIDTH), .K(K)) bus ();

   basemul_acc #(.WIDTH(WIDTH), .K(K), .Q(KYBER_Q), .FQMUL_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   pulse_t obs_q[$];
   pulse_t exp_q[$];
   int     total = 0, bad = 0, cyc = 0, hold_bad = 0;
   int     prev_r0 = 0, prev_r1 = 0, last_cyc = 0;
   longint m_acc0 = 0, m_acc1 = 0;
   int     m_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int centred(input longint x);
      longint m = x % KYBER_Q;
      if (m < 0) m += KYBER_Q;
      if (m > (KYBER_Q - 1) / 2) m -= KYBER_Q;
      return int'(m);
   endfunction

   function automatic int rnd();
      return int'($urandom_range(6656)) - 3328;
   endfunction

   // One clock of stimulus: observe outputs, drive a term, update the model.
   task automatic step(input logic v, input logic neg, input int a0, input int a1,
                       input int b0, input int b1, input int z);
      longint zp, mm, t0, t1;
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
         obs_q.push_back('{int'(bus.r0), int'(bus.r1), cyc});
      end else if (int'(bus.r0) != prev_r0 || int'(bus.r1) != prev_r1) begin
         hold_bad++;
      end
      prev_r0 = int'(bus.r0);
      prev_r1 = int'(bus.r1);
      bus.in_valid = v;
      bus.in_neg   = neg;
      bus.a0       = coef_t'(a0);
      bus.a1       = coef_t'(a1);
      bus.b0       = coef_t'(b0);
      bus.b1       = coef_t'(b1);
      bus.zeta     = coef_t'(z);
      if (v && rst_n) begin
         zp = neg ? -longint'(z) : longint'(z);
         mm = (longint'(a1) * b1 % KYBER_Q) * RINV % KYBER_Q;
         t0 = longint'(a0) * b0 * RINV + (mm * zp % KYBER_Q) * RINV;
         t1 = (longint'(a0) * b1 + longint'(a1) * b0) * RINV;
         m_acc0 = (m_acc0 + t0) % KYBER_Q;
         m_acc1 = (m_acc1 + t1) % KYBER_Q;
         m_cnt++;
         last_cyc = cyc;
         if (m_cnt == K) begin
            exp_q.push_back('{centred(m_acc0), centred(m_acc1), cyc + LAT});
            m_acc0 = 0;
            m_acc1 = 0;
            m_cnt  = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'($urandom), rnd(), rnd(), rnd(), rnd(), rnd());
   endtask

   task automatic hold_reset(input int n);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      prev_r0      = 0;
      prev_r1      = 0;
      m_acc0       = 0;
      m_acc1       = 0;
      m_cnt        = 0;
      exp_q.delete();
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_test();
      obs_q.delete();
      exp_q.delete();
      hold_bad = 0;
   endtask

   task automatic test_reset();
      hold_reset(3);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.r0 !== '0) begin bad++; $display("FAIL reset_r0 got=%0d want=0", bus.r0); end
      total++; if (bus.r1 !== '0) begin bad++; $display("FAIL reset_r1 got=%0d want=0", bus.r1); end
      total++; if (bus.term_idx !== '0) begin bad++; $display("FAIL reset_term_idx got=%0d want=0", bus.term_idx); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_sum(input logic neg, input int er0, input int er1);
      begin_test();
      repeat (K) step(1'b1, neg, R, R, 5, 7, R);
      idle(LAT + 3);
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL single_neg%0b pulses got=%0d want=1", neg, obs_q.size()); end
      if (obs_q.size() > 0) begin
         total++; if (obs_q[0].r0 !== er0) begin bad++; $display("FAIL single_neg%0b r0 got=%0d want=%0d", neg, obs_q[0].r0, er0); end
         total++; if (obs_q[0].r1 !== er1) begin bad++; $display("FAIL single_neg%0b r1 got=%0d want=%0d", neg, obs_q[0].r1, er1); end
         total++; if (obs_q[0].cyc !== last_cyc + LAT) begin bad++; $display("FAIL single_neg%0b latency got=%0d want=%0d", neg, obs_q[0].cyc - last_cyc, LAT); end
      end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL single_neg%0b hold got=%0d want=0", neg, hold_bad); end
   endtask

   task automatic test_bubbles();
      logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      begin_test();
      foreach (pat[i]) begin
         if (pat[i]) step(1'b1, 1'b0, R, R, 5, 7, R);
         else        step(1'b0, 1'($urandom), rnd(), rnd(), rnd(), rnd(), rnd());
      end
      idle(LAT + 3);
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL bubbles pulses got=%0d want=1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         total++; if (obs_q[0].r0 !== 36 || obs_q[0].r1 !== 36) begin bad++; $display("FAIL bubbles result got=%0d,%0d want=36,36", obs_q[0].r0, obs_q[0].r1); end
         total++; if (obs_q[0].cyc !== last_cyc + LAT) begin bad++; $display("FAIL bubbles latency got=%0d want=%0d", obs_q[0].cyc - last_cyc, LAT); end
      end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL bubbles hold got=%0d want=0", hold_bad); end
   endtask

   task automatic test_back_to_back();
      begin_test();
      repeat (K) step(1'b1, 1'b0, R, R, 5, 7, R);
      repeat (K) step(1'b1, 1'b0, R, R, 1, 1, R);
      idle(LAT + 3);
      total++; if (obs_q.size() != 2) begin bad++; $display("FAIL b2b pulses got=%0d want=2", obs_q.size()); end
      if (obs_q.size() == 2) begin
         total++; if (obs_q[0].r0 !== 36 || obs_q[0].r1 !== 36) begin bad++; $display("FAIL b2b first got=%0d,%0d want=36,36", obs_q[0].r0, obs_q[0].r1); end
         total++; if (obs_q[1].r0 !== 6 || obs_q[1].r1 !== 6) begin bad++; $display("FAIL b2b second got=%0d,%0d want=6,6", obs_q[1].r0, obs_q[1].r1); end
         total++; if (obs_q[1].cyc - obs_q[0].cyc !== K) begin bad++; $display("FAIL b2b spacing got=%0d want=%0d", obs_q[1].cyc - obs_q[0].cyc, K); end
      end
   endtask

   task automatic test_reset_mid_sum();
      begin_test();
      repeat (2) step(1'b1, 1'b0, R, R, 5, 7, R);
      hold_reset(2);
      total++; if (bus.out_valid !== 1'b0 || bus.r0 !== '0 || bus.r1 !== '0) begin bad++; $display("FAIL midrst_outputs got=%b,%0d,%0d want=0,0,0", bus.out_valid, bus.r0, bus.r1); end
      total++; if (bus.term_idx !== '0) begin bad++; $display("FAIL midrst_term_idx got=%0d want=0", bus.term_idx); end
      rst_n = 1'b1;
      repeat (K) step(1'b1, 1'b0, R, R, 5, 7, R);
      idle(LAT + 3);
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL midrst pulses got=%0d want=1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         total++; if (obs_q[0].r0 !== 36 || obs_q[0].r1 !== 36) begin bad++; $display("FAIL midrst result got=%0d,%0d want=36,36", obs_q[0].r0, obs_q[0].r1); end
      end
   endtask

   task automatic test_wrap();
      begin_test();
      total++; if (bus.term_idx !== '0) begin bad++; $display("FAIL wrap term_idx start got=%0d want=0", bus.term_idx); end
      for (int i = 0; i < K; i++) begin
         step(1'b1, 1'b0, R, 0, 1664, 0, R);
         @(posedge clk);
         #1;
         total++; if (int'(bus.term_idx) !== (i + 1) % K) begin bad++; $display("FAIL wrap term_idx got=%0d want=%0d", bus.term_idx, (i + 1) % K); end
      end
      idle(LAT + 3);
      // Each term contributes 1664; 3*1664 = 4992 reduces to 1663 mod 3329
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL wrap pulses got=%0d want=1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         total++; if (obs_q[0].r0 !== 1663 || obs_q[0].r1 !== 0) begin bad++; $display("FAIL wrap result got=%0d,%0d want=1663,0", obs_q[0].r0, obs_q[0].r1); end
      end
   endtask

   task automatic test_random();
      begin_test();
      for (int i = 0; i < 90; i++) begin
         step(($urandom % 4) != 0, 1'($urandom), rnd(), rnd(), rnd(), rnd(), rnd());
      end
      while (m_cnt != 0) step(1'b1, 1'($urandom), rnd(), rnd(), rnd(), rnd(), rnd());
      idle(LAT + 3);
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL random pulses got=%0d want=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL random sum%0d got=%0d,%0d@%0d want=%0d,%0d@%0d", i,
                     obs_q[i].r0, obs_q[i].r1, obs_q[i].cyc, exp_q[i].r0, exp_q[i].r1, exp_q[i].cyc);
         end
      end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL random hold got=%0d want=0", hold_bad); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_neg   = 1'b0;
      bus.a0       = '0;
      bus.a1       = '0;
      bus.b0       = '0;
      bus.b1       = '0;
      bus.zeta     = '0;
      test_reset();
      test_single_sum(1'b0, 36, 36);
      test_single_sum(1'b1, -6, 36);
      test_bubbles();
      test_back_to_back();
      test_reset_mid_sum();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
